param_loop_counter: RTL and testbench



---
 rtl/param_loop_counter_if.sv | 67 ++++++
 rtl/param_loop_counter.sv | 136 +++++++++++++
 tb/tb_param_loop_counter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_loop_counter_if.sv
// ----------------------------------------------------------------------------
// param_loop_counter_if
//
// Groups the control and status signals of param_loop_counter.
//   master : drives start/en/up_dn/one_shot (and load/load_val), observes status
//   slave  : the counter itself
//
// Signals:
//   start     pulse, launches a run from IDLE or STOPPED
//   en        count enable while running
//   up_dn     1 = count up, 0 = count down
//   one_shot  1 = stop at terminal, 0 = wrap
//   load      synchronous load      (PARAM_LOOP_COUNTER_LOAD_EN only)
//   load_val  value to load         (PARAM_LOOP_COUNTER_LOAD_EN only)
//   count     current count
//   tc        terminal-count flag (registered)
//   running   high while counting
//   done      sticky, high once a one-shot run has finished
//
// Optional feature macro: PARAM_LOOP_COUNTER_LOAD_EN adds load/load_val.
// ----------------------------------------------------------------------------
interface param_loop_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             en;
    logic             up_dn;
    logic             one_shot;
`ifdef PARAM_LOOP_COUNTER_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] load_val;
`endif
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;
    logic             done;

    modport master (
`ifdef PARAM_LOOP_COUNTER_LOAD_EN
        output load,
        output load_val,
`endif
        output start,
        output en,
        output up_dn,
        output one_shot,
        input  count,
        input  tc,
        input  running,
        input  done
    );

    modport slave (
`ifdef PARAM_LOOP_COUNTER_LOAD_EN
        input  load,
        input  load_val,
`endif
        input  start,
        input  en,
        input  up_dn,
        input  one_shot,
        output count,
        output tc,
        output running,
        output done
    );
endinterface

// File: rtl/param_loop_counter.sv
// ----------------------------------------------------------------------------
// param_loop_counter
//
// Parametrised up/down loop counter with an IDLE / RUN / STOPPED controller.
// Counts between 0 and TERMINAL. In one-shot mode it stops at the active
// terminal and raises the sticky done flag; in wrap mode it wraps to the
// opposite end and flags tc once per pass.
//
// Parameters:
//   WIDTH     counter width in bits (1..32)
//   TERMINAL  terminal count, 1..2**WIDTH-1 (default all ones)
//
// Ports:
//   clk   single clock, all logic on posedge
//   rst   synchronous, active-high reset
//   bus   param_loop_counter_if.slave (control inputs, status outputs)
//
// Optional feature macro: PARAM_LOOP_COUNTER_LOAD_EN
//   Adds a synchronous load (priority rst > load > start > step). Load values
//   above TERMINAL clamp to TERMINAL.
//
// All outputs come straight from flops or from a decode of the state flop,
// so there is no combinational path from any input to any output.
// ----------------------------------------------------------------------------
module param_loop_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = {WIDTH{1'b1}}
) (
    input logic                 clk,
    input logic                 rst,
    param_loop_counter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_STOPPED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] term;      // active terminal for the current direction
    logic [WIDTH-1:0] step_val;  // next count if a step is taken
`ifdef PARAM_LOOP_COUNTER_LOAD_EN
    logic [WIDTH-1:0] load_clamped;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-count logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = tc_q;

        term = bus.up_dn ? TERMINAL : '0;

        // Wrapping is explicit at both ends, so the count never leaves
        // 0..TERMINAL even when TERMINAL is below the WIDTH maximum.
        if (bus.up_dn) begin
            step_val = (count_q == TERMINAL) ? '0 : count_q + WIDTH'(1);
        end else begin
            step_val = (count_q == '0) ? TERMINAL : count_q - WIDTH'(1);
        end

`ifdef PARAM_LOOP_COUNTER_LOAD_EN
        load_clamped = (bus.load_val > TERMINAL) ? TERMINAL : bus.load_val;

        if (bus.load) begin
            count_d = load_clamped;
            if (state_q == S_RUN) begin
                tc_d = (load_clamped == term);
                // Loading the terminal during a one-shot run ends the run.
                if (bus.one_shot && (load_clamped == term)) begin
                    state_d = S_STOPPED;
                end
            end else begin
                tc_d = 1'b0;
            end
        end else
`endif
        if (state_q != S_RUN) begin
            if (bus.start) begin
                count_d = bus.up_dn ? '0 : TERMINAL;
                state_d = S_RUN;
                tc_d    = 1'b0;
            end
        end else if (bus.en) begin
            if (bus.one_shot && (count_q == term)) begin
                // Already sitting on the terminal (e.g. one_shot or up_dn
                // changed mid-run): stop without moving.
                state_d = S_STOPPED;
                tc_d    = 1'b1;
            end else begin
                count_d = step_val;
                tc_d    = (step_val == term);
                if (bus.one_shot && (step_val == term)) begin
                    state_d = S_STOPPED;
                end
            end
        end else begin
            // Count holds; tc follows the (possibly new) direction.
            tc_d = (count_q == term);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.running = (state_q == S_RUN);
    assign bus.done    = (state_q == S_STOPPED);

endmodule

// File: tb/tb_param_loop_counter.sv
// ----------------------------------------------------------------------------
// tb_param_loop_counter
//
// Drives two counters (WIDTH=4 with TERMINAL=9 and TERMINAL=15) with the same
// stimulus and compares both against a behavioural model every cycle, plus
// hand-derived expectations for directed sequences.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_param_loop_counter;

    logic clk;
    logic rst;

    param_loop_counter_if #(.WIDTH(4)) if9 ();
    param_loop_counter_if #(.WIDTH(4)) if15 ();

    param_loop_counter #(.WIDTH(4), .TERMINAL(4'd9)) u9 (
        .clk (clk),
        .rst (rst),
        .bus (if9.slave)
    );

    param_loop_counter #(.WIDTH(4), .TERMINAL(4'd15)) u15 (
        .clk (clk),
        .rst (rst),
        .bus (if15.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ------------------------------------------------------------------
    // Reference model: index 0 -> TERMINAL 9, index 1 -> TERMINAL 15
    // ------------------------------------------------------------------
    int tv[2] = '{9, 15};
    int m_cnt[2];
    bit m_tc[2];
    bit m_run[2];
    bit m_done[2];

    task automatic model_edge(input int k, input bit r, input bit s, input bit e,
                              input bit u, input bit o, input bit ld, input int lv);
        int t;
        int term;
        int n;
        t    = tv[k];
        term = u ? t : 0;
        n    = t + 1;
        if (r) begin
            m_cnt[k] = 0; m_tc[k] = 0; m_run[k] = 0; m_done[k] = 0;
        end else if (ld) begin
            m_cnt[k] = (lv > t) ? t : lv;
            if (m_run[k]) begin
                m_tc[k] = (m_cnt[k] == term);
                if (o && m_tc[k]) begin m_run[k] = 0; m_done[k] = 1; end
            end else begin
                m_tc[k] = 0;
            end
        end else if (!m_run[k]) begin
            if (s) begin
                m_cnt[k] = u ? 0 : t; m_run[k] = 1; m_done[k] = 0; m_tc[k] = 0;
            end
        end else if (!e) begin
            m_tc[k] = (m_cnt[k] == term);
        end else if (o && m_cnt[k] == term) begin
            m_run[k] = 0; m_done[k] = 1; m_tc[k] = 1;
        end else begin
            m_cnt[k] = u ? (m_cnt[k] + 1) % n : (m_cnt[k] + n - 1) % n;
            m_tc[k]  = (m_cnt[k] == term);
            if (o && m_tc[k]) begin m_run[k] = 0; m_done[k] = 1; end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " t9.count"},    int'(if9.count),    m_cnt[0]);
        check({tag, " t9.tc"},       int'(if9.tc),       int'(m_tc[0]));
        check({tag, " t9.running"},  int'(if9.running),  int'(m_run[0]));
        check({tag, " t9.done"},     int'(if9.done),     int'(m_done[0]));
        check({tag, " t15.count"},   int'(if15.count),   m_cnt[1]);
        check({tag, " t15.tc"},      int'(if15.tc),      int'(m_tc[1]));
        check({tag, " t15.running"}, int'(if15.running), int'(m_run[1]));
        check({tag, " t15.done"},    int'(if15.done),    int'(m_done[1]));
    endtask

    // One clock: apply inputs, take the edge, update model, sample #1 later.
    task automatic cycle(input string tag, input bit r, input bit s, input bit e,
                         input bit u, input bit o, input bit ld, input int lv);
        bit ld_eff;
`ifdef PARAM_LOOP_COUNTER_LOAD_EN
        ld_eff = ld;
        if9.load      = ld;  if9.load_val  = 4'(lv);
        if15.load     = ld;  if15.load_val = 4'(lv);
`else
        ld_eff = 1'b0;
`endif
        rst = r;
        if9.start  = s; if9.en  = e; if9.up_dn  = u; if9.one_shot  = o;
        if15.start = s; if15.en = e; if15.up_dn = u; if15.one_shot = o;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, r, s, e, u, o, ld_eff, lv);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit r, s, e, u, o;
        int cnt;
        bit tc, run, done;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int first_tc;
        int second_tc;
        int tc_hits;
        bit ever_done;

        rst = 1'b1;
        if9.start = 0; if9.en = 0; if9.up_dn = 1; if9.one_shot = 0;
        if15.start = 0; if15.en = 0; if15.up_dn = 1; if15.one_shot = 0;
`ifdef PARAM_LOOP_COUNTER_LOAD_EN
        if9.load = 0; if9.load_val = '0; if15.load = 0; if15.load_val = '0;
`endif

        // --------------------------------------------------------------
        // Table: expected outputs for TERMINAL=9
        //            r  s  e  u  o   cnt tc run done
        // --------------------------------------------------------------
        vecs[0]  = '{1, 0, 0, 1, 0,   0, 0, 0, 0};  // reset
        vecs[1]  = '{0, 1, 1, 1, 0,   0, 0, 1, 0};  // start up, wrap
        vecs[2]  = '{0, 0, 1, 1, 0,   1, 0, 1, 0};
        vecs[3]  = '{0, 0, 1, 1, 0,   2, 0, 1, 0};
        vecs[4]  = '{0, 1, 1, 1, 0,   3, 0, 1, 0};  // start in RUN ignored
        vecs[5]  = '{0, 0, 1, 1, 0,   4, 0, 1, 0};  // en 1,0,1,0 from 3
        vecs[6]  = '{0, 0, 0, 1, 0,   4, 0, 1, 0};
        vecs[7]  = '{0, 0, 1, 1, 0,   5, 0, 1, 0};
        vecs[8]  = '{0, 0, 0, 1, 0,   5, 0, 1, 0};
        vecs[9]  = '{0, 0, 1, 0, 0,   4, 0, 1, 0};  // direction flipped
        vecs[10] = '{0, 0, 1, 0, 0,   3, 0, 1, 0};
        vecs[11] = '{0, 0, 1, 1, 0,   4, 0, 1, 0};
        vecs[12] = '{0, 0, 1, 1, 0,   5, 0, 1, 0};
        vecs[13] = '{0, 0, 1, 1, 0,   6, 0, 1, 0};
        vecs[14] = '{1, 1, 1, 1, 0,   0, 0, 0, 0};  // reset beats start
        vecs[15] = '{0, 0, 1, 1, 0,   0, 0, 0, 0};  // idle: no step
        vecs[16] = '{0, 1, 1, 0, 1,   9, 0, 1, 0};  // start down one-shot
        vecs[17] = '{0, 0, 1, 0, 1,   8, 0, 1, 0};

        for (int i = 0; i < 18; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(tag, vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].u, vecs[i].o, 0, 0);
            check({tag, " tbl.count"},   int'(if9.count),   vecs[i].cnt);
            check({tag, " tbl.tc"},      int'(if9.tc),      int'(vecs[i].tc));
            check({tag, " tbl.running"}, int'(if9.running), int'(vecs[i].run));
            check({tag, " tbl.done"},    int'(if9.done),    int'(vecs[i].done));
        end

        // --------------------------------------------------------------
        // TERMINAL=15, up, one-shot: done and tc rise at start+15
        // --------------------------------------------------------------
        cycle("os15 rst", 1, 0, 0, 1, 1, 0, 0);
        cycle("os15 start", 0, 1, 1, 1, 1, 0, 0);
        check("os15 start count", int'(if15.count), 0);
        for (int i = 1; i <= 15; i++) begin
            cycle($sformatf("os15 step%0d", i), 0, 0, 1, 1, 1, 0, 0);
            if (i == 14) check("os15 done before terminal", int'(if15.done), 0);
        end
        check("os15 count at terminal", int'(if15.count), 15);
        check("os15 tc at terminal", int'(if15.tc), 1);
        check("os15 done at terminal", int'(if15.done), 1);
        check("os15 running at terminal", int'(if15.running), 0);
        cycle("os15 hold", 0, 0, 1, 1, 1, 0, 0);
        check("os15 count holds", int'(if15.count), 15);

        // --------------------------------------------------------------
        // TERMINAL=9, up, wrap: tc at count 9 only, period 10
        // --------------------------------------------------------------
        cycle("wrap rst", 1, 0, 0, 1, 0, 0, 0);
        cycle("wrap start", 0, 1, 1, 1, 0, 0, 0);
        first_tc = -1; second_tc = -1; tc_hits = 0; ever_done = 0;
        for (int i = 1; i <= 25; i++) begin
            cycle($sformatf("wrap step%0d", i), 0, 0, 1, 1, 0, 0, 0);
            if (if9.tc) begin
                tc_hits++;
                if (first_tc < 0) first_tc = i;
                else if (second_tc < 0) second_tc = i;
            end
            if (if9.done) ever_done = 1;
        end
        check("wrap first tc edge", first_tc, 9);
        check("wrap second tc edge", second_tc, 19);
        check("wrap tc hits", tc_hits, 2);
        check("wrap done stays low", int'(ever_done), 0);

        // --------------------------------------------------------------
        // TERMINAL=9, down, one-shot: done at start+9, restart clears it
        // --------------------------------------------------------------
        cycle("dn rst", 1, 0, 0, 0, 1, 0, 0);
        cycle("dn start", 0, 1, 1, 0, 1, 0, 0);
        check("dn start count", int'(if9.count), 9);
        for (int i = 1; i <= 9; i++) begin
            cycle($sformatf("dn step%0d", i), 0, 0, 1, 0, 1, 0, 0);
            if (i == 8) check("dn done before terminal", int'(if9.done), 0);
        end
        check("dn count at terminal", int'(if9.count), 0);
        check("dn done at terminal", int'(if9.done), 1);
        check("dn tc at terminal", int'(if9.tc), 1);
        cycle("dn restart", 0, 1, 1, 0, 1, 0, 0);
        check("dn restart count", int'(if9.count), 9);
        check("dn restart done", int'(if9.done), 0);
        check("dn restart running", int'(if9.running), 1);

`ifdef PARAM_LOOP_COUNTER_LOAD_EN
        // --------------------------------------------------------------
        // Load: clamp, beats start, one-shot load to terminal stops
        // --------------------------------------------------------------
        cycle("ld rst", 1, 0, 0, 1, 1, 0, 0);
        cycle("ld clamp", 0, 1, 1, 1, 1, 1, 12);
        check("ld clamp count", int'(if9.count), 9);
        check("ld clamp running", int'(if9.running), 0);
        check("ld t15 count", int'(if15.count), 12);
        cycle("ld start", 0, 1, 0, 0, 1, 0, 0);
        check("ld start count", int'(if9.count), 9);
        cycle("ld zero", 0, 0, 0, 0, 1, 1, 0);
        check("ld zero count", int'(if9.count), 0);
        check("ld zero done", int'(if9.done), 1);
        check("ld zero tc", int'(if9.tc), 1);
        check("ld zero running", int'(if9.running), 0);
`endif

        // --------------------------------------------------------------
        // Randomised stimulus against the model
        // --------------------------------------------------------------
        cycle("rnd rst", 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit r, s, e, u, o, ld;
            int lv;
            r  = ($urandom_range(63) == 0);
            s  = ($urandom_range(7) == 0);
            e  = ($urandom_range(3) != 0);
            u  = ($urandom_range(7) != 0) ? if9.up_dn : ~if9.up_dn;
            o  = ($urandom_range(5) != 0) ? if9.one_shot : ~if9.one_shot;
            ld = ($urandom_range(15) == 0);
            lv = int'($urandom_range(15));
            cycle($sformatf("rnd%0d", i), r, s, e, u, o, ld, lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
